// File: rtl/fft_ctrl_s00_axi_slave.sv
// AXI4-Lite responder for the fft_ctrl S00_AXI port: four 32-bit control
// registers with per-register write pulses and an FFT start strobe.
module fft_ctrl_s00_axi_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3_o,
  output logic [3:0]                        wr_pulse_o,
  output logic                              start_o
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic {
    W_ACCEPT = 1'b0,
    W_RESP   = 1'b1
  } wr_state_t;

  wr_state_t state_reg, state_next;

  // Held low through reset and for the first edge after it, so every
  // ready output reads 0 until the bus is actually serviceable.
  logic active_reg;

  logic          aw_held_reg;
  logic [1:0]    aw_sel_reg;
  logic          w_held_reg;
  logic [DW-1:0] w_data_reg;
  logic [SW-1:0] w_strb_reg;

  logic [DW-1:0] rdata_reg;
  logic          rvalid_reg;
  logic [3:0]    wr_pulse_reg;
  logic          start_reg;

  logic          aw_ready;
  logic          w_ready;
  logic          ar_ready;
  logic          aw_fire;
  logic          w_fire;
  logic          ar_fire;
  logic          commit;
  logic          bvalid;
  logic [3:0]    hit_vec;
  logic [DW-1:0] regs [4];

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_ready = active_reg && (state_reg == W_ACCEPT) && !aw_held_reg;
  assign w_ready  = active_reg && (state_reg == W_ACCEPT) && !w_held_reg;
  assign ar_ready = active_reg && !rvalid_reg;

  assign aw_fire = S_AXI_AWVALID && aw_ready;
  assign w_fire  = S_AXI_WVALID && w_ready;
  assign ar_fire = S_AXI_ARVALID && ar_ready;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_reg  <= W_ACCEPT;
      active_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      active_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    commit     = 1'b0;
    bvalid     = 1'b0;
    case (state_reg)
      W_ACCEPT: begin
        if (aw_held_reg && w_held_reg) begin
          commit     = 1'b1;
          state_next = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (S_AXI_BREADY) begin
          state_next = W_ACCEPT;
        end
      end
      default: state_next = W_ACCEPT;
    endcase
  end

  // Address and data are captured independently; the commit happens on the
  // edge after both are present, which also frees both latches.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_held_reg <= 1'b0;
      aw_sel_reg  <= 2'd0;
      w_held_reg  <= 1'b0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
    end else if (commit) begin
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
    end else begin
      if (aw_fire) begin
        aw_held_reg <= 1'b1;
        aw_sel_reg  <= S_AXI_AWADDR[3:2];
      end
      if (w_fire) begin
        w_held_reg <= 1'b1;
        w_data_reg <= S_AXI_WDATA;
        w_strb_reg <= S_AXI_WSTRB;
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_reg
    logic [DW-1:0] word_reg;

    assign hit_vec[gi] = commit && (aw_sel_reg == 2'(gi)) && (|w_strb_reg);
    assign regs[gi]    = word_reg;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
        word_reg <= '0;
      end else if (hit_vec[gi]) begin
        for (int b = 0; b < SW; b++) begin
          if (w_strb_reg[b]) begin
            word_reg[8*b +: 8] <= w_data_reg[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_pulse_reg <= 4'd0;
      start_reg    <= 1'b0;
    end else begin
      wr_pulse_reg <= hit_vec;
      start_reg    <= hit_vec[0] && w_strb_reg[0] && w_data_reg[0];
    end
  end

  // A read sampling a register on its commit edge returns the pre-write value.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
    end else if (ar_fire) begin
      rvalid_reg <= 1'b1;
      rdata_reg  <= regs[S_AXI_ARADDR[3:2]];
    end else if (rvalid_reg && S_AXI_RREADY) begin
      rvalid_reg <= 1'b0;
    end
  end

  assign S_AXI_AWREADY = aw_ready;
  assign S_AXI_WREADY  = w_ready;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_ARREADY = ar_ready;
  assign S_AXI_RDATA   = rdata_reg;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_reg;

  assign reg0_o     = regs[0];
  assign reg1_o     = regs[1];
  assign reg2_o     = regs[2];
  assign reg3_o     = regs[3];
  assign wr_pulse_o = wr_pulse_reg;
  assign start_o    = start_reg;

endmodule

// File: doc/fft_ctrl_s00_axi_slave.md
# fft_ctrl_s00_axi_slave

AXI4-Lite responder for the fft_ctrl IP's S00_AXI port: it terminates the master's write and read transactions into a bank of four 32-bit control registers. It drives register contents, per-register write pulses and an FFT start strobe into the fft_ctrl core. Write and read channels run independently; every response is OKAY.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; addr[3:2] selects register 0..3.
- S_AXI_ACLK  in  1  sole clock; all logic on rising edge.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  always 2'b00.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  4  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- reg0_o..reg3_o  out  32 each  current register contents.
- wr_pulse_o  out  4  bit k high for one cycle when register k commits a write.
- start_o  out  1  one-cycle pulse on a reg0 write with WSTRB[0]=1 and WDATA[0]=1.

## Operation
- Write FSM has two states, W_ACCEPT and W_RESP.
- W_ACCEPT:
  - AWREADY=1 while no address is latched; WREADY=1 while no data is latched.
  - AW and W are accepted in either order or in the same cycle, and each is latched on its own handshake.
  - When both are latched, the write commits: byte k of the addressed register takes WDATA[8k+7:8k] if WSTRB[k]=1.
  - Both latches clear, the FSM moves to W_RESP, and BVALID is set.
- W_RESP:
  - AWREADY=0, WREADY=0, BVALID=1.
  - On BREADY=1, clear BVALID and return to W_ACCEPT.
- WSTRB=4'b0000: the write completes with an OKAY response, leaves the register unchanged, and raises no wr_pulse_o or start_o.
- Read path:
  - ARREADY=1 whenever RVALID=0.
  - On an AR handshake, RDATA is loaded with the register at ARADDR[3:2] and RVALID is set.
  - RDATA and RVALID hold until RREADY=1. ARREADY stays 0 while RVALID=1.
- Address bits [1:0] are ignored. All four addresses map to read/write registers; there is no decode error.
- start_o does not clear reg0; reg0 bit 0 reads back as written.

## Timing
- Reset (ARESETN=0, asynchronous): all outputs are 0, including AWREADY, WREADY, ARREADY and all registers. The write FSM goes to W_ACCEPT and the latches clear.
- The first rising edge after ARESETN=1 sets AWREADY=WREADY=ARREADY=1.
- Write latency: the second of the AW/W handshakes occurs at edge N. The register update, BVALID=1, wr_pulse_o and start_o all become visible after edge N+1. The pulses last exactly one cycle.
- Minimum write throughput is one transaction per 3 cycles with BREADY held at 1.
- Read latency: AR handshake at edge N gives RVALID=1 and valid RDATA after edge N. With RREADY held at 1, one read completes every 2 cycles.
- Simultaneous read and write commit to the same register at the same edge: RDATA returns the old value, and the next read returns the new value.
- Backpressure: while BREADY=0, BVALID, AWREADY=0 and WREADY=0 all hold. While RREADY=0, RDATA and RVALID hold, and ARREADY holds 0.
- Reset mid-transaction drops BVALID/RVALID immediately and discards any latched AW/W. The master must reissue.

## Test plan
- Sequential writes of 1,2,3,4 to addresses 0x0,0x4,0x8,0xC with WSTRB=4'hF, then read back: RDATA = 1,2,3,4, all BRESP and RRESP = 0, wr_pulse_o bits 0..3 each pulse once.
- Write 0xAABBCCDD to 0x4, then write 0x11223344 with WSTRB=4'b0101: readback is 0xAA22CC44.
- AW presented 3 cycles before W, then W presented 3 cycles before AW: both commit once, and BVALID rises exactly 1 cycle after the later handshake.
- Hold BREADY=0 for 5 cycles after a write: BVALID stays 1, AWREADY and WREADY stay 0, and a second AW is not accepted until the cycle after BREADY=1.
- Write 0x1 to 0x0: start_o pulses one cycle and reg0 reads back 1. Writing 0x0 to 0x0 produces no start_o, and writing 0x1 with WSTRB=0 produces no start_o.
- Deassert ARESETN while BVALID=1 and while RVALID=1: both drop in the same cycle, all registers read 0 after reset release, and the next transaction completes normally.
